// File: rtl/riscv_run_pkg.sv
// Shared types and status codes for the RISC-V run controller.
package riscv_run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } run_state_e;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_HALT    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_RSTFAIL = 2'b11;

endpackage

// File: rtl/riscv_pc_stall_det.sv
// Self-loop detector: counts consecutive cycles in which the core's pc does not change.
module riscv_pc_stall_det #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned STALL_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            en_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            stall_hit_o
);

    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    logic [XLEN-1:0]    prevPc_q, prevPc_d;
    logic               prevValid_q, prevValid_d;
    logic [STALL_W-1:0] stallCnt_q, stallCnt_d;
    logic               pcRepeat;

    // The hit fires on the comparison that completes the run of equal pcs, not one later.
    always_comb begin
        pcRepeat    = prevValid_q && (pc_i == prevPc_q);
        stall_hit_o = en_i && pcRepeat && (stallCnt_q == STALL_W'(STALL_LIMIT - 1));
        prevPc_d    = prevPc_q;
        prevValid_d = prevValid_q;
        stallCnt_d  = stallCnt_q;
        if (clear_i) begin
            prevPc_d    = '0;
            prevValid_d = 1'b0;
            stallCnt_d  = '0;
        end else if (en_i) begin
            prevPc_d    = pc_i;
            prevValid_d = 1'b1;
            stallCnt_d  = pcRepeat ? stallCnt_q + STALL_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prevPc_q    <= '0;
            prevValid_q <= 1'b0;
            stallCnt_q  <= '0;
        end else begin
            prevPc_q    <= prevPc_d;
            prevValid_q <= prevValid_d;
            stallCnt_q  <= stallCnt_d;
        end
    end

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller: holds the core in reset, checks the reset vector, then runs it
// until a self-loop halt or a cycle-budget timeout, reporting a sticky status.
module riscv_run_ctrl
    import riscv_run_pkg::*;
#(
    parameter int unsigned      XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_PC    = '0,
    parameter int unsigned      HOLD_CYCLES = 4,
    parameter int unsigned      MAX_CYCLES  = 4096,
    parameter int unsigned      STALL_LIMIT = 8,
    parameter int unsigned      CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [XLEN-1:0]  pc,
    output logic             core_rst_n,
    output logic             running,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [XLEN-1:0]  halt_pc
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    run_state_e        state_q, state_d;
    logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
    logic [CNT_W-1:0]  cycleCnt_q, cycleCnt_d;
    logic [1:0]        status_q, status_d;
    logic [XLEN-1:0]   haltPc_q, haltPc_d;
    logic              stallClr, stallEn, stallHit;

    riscv_pc_stall_det #(
        .XLEN       (XLEN),
        .STALL_LIMIT(STALL_LIMIT)
    ) u_stall_det (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (stallClr),
        .en_i       (stallEn),
        .pc_i       (pc),
        .stall_hit_o(stallHit)
    );

    // A reset-vector mismatch ends HOLD even on its last cycle; halt outranks timeout in RUN.
    always_comb begin
        state_d    = state_q;
        holdCnt_d  = holdCnt_q;
        cycleCnt_d = cycleCnt_q;
        status_d   = status_q;
        haltPc_d   = haltPc_q;
        stallClr   = 1'b0;
        stallEn    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = HOLD;
                    holdCnt_d = '0;
                end
            end
            HOLD: begin
                holdCnt_d = holdCnt_q + HOLD_W'(1);
                if (pc != RESET_PC) begin
                    state_d  = DONE;
                    status_d = ST_RSTFAIL;
                    haltPc_d = pc;
                end else if (holdCnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d    = RUN;
                    cycleCnt_d = '0;
                    stallClr   = 1'b1;
                end
            end
            RUN: begin
                stallEn    = 1'b1;
                cycleCnt_d = cycleCnt_q + CNT_W'(1);
                if (stallHit) begin
                    state_d  = DONE;
                    status_d = ST_HALT;
                    haltPc_d = pc;
                end else if (cycleCnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d  = DONE;
                    status_d = ST_TIMEOUT;
                    haltPc_d = pc;
                end
            end
            DONE: begin
                if (start) begin
                    state_d    = HOLD;
                    status_d   = ST_NONE;
                    cycleCnt_d = '0;
                    holdCnt_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            holdCnt_q  <= '0;
            cycleCnt_q <= '0;
            status_q   <= ST_NONE;
            haltPc_q   <= '0;
        end else begin
            state_q    <= state_d;
            holdCnt_q  <= holdCnt_d;
            cycleCnt_q <= cycleCnt_d;
            status_q   <= status_d;
            haltPc_q   <= haltPc_d;
        end
    end

    assign core_rst_n = (state_q == RUN);
    assign running    = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign status     = status_q;
    assign cycle_cnt  = cycleCnt_q;
    assign halt_pc    = haltPc_q;

endmodule
